// File: rtl/g_macro_pkg.sv
// Shared definitions for arbiters that front the g_bufb global-buffer macro.
// Holds the arbiter state encoding and the idle level of the buffer's AN pin.
package g_macro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // AN high means Y low: the shared line rests deasserted.
  localparam logic G_BUF_IDLE_AN = 1'b1;
  localparam int   G_MAXHOLD_DEF = 16;

endpackage

// File: rtl/g_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, wrapping.
// Kept free of any state so other shared-net arbiters can reuse it.
module g_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  int            k;
  logic [PW-1:0] k_idx;

  // Walk N positions starting at ptr; the first hit wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    k       = 0;
    k_idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) begin
        k = k - N;
      end
      k_idx = PW'(k);
      if (!any && req[k_idx]) begin
        any     = 1'b1;
        win_idx = k_idx;
      end
    end
    if (any) begin
      win[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/g_bufb_arb.sv
// Round-robin owner arbiter for one inverting g_bufb line: grants the line,
// forwards the owner's data active-low, limits hold time and adds a dead cycle.
module g_bufb_arb
  import g_macro_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAXHOLD = G_MAXHOLD_DEF
) (
  input  logic         CK,
  input  logic         CD,
  input  logic [N-1:0] REQ,
  input  logic [N-1:0] DIN,
  output logic [N-1:0] GNT,
  output logic         AN,
  output logic         BUSY
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HMAX  = HW'(MAXHOLD);
  localparam logic [PW-1:0] PLAST = PW'(N - 1);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [HW-1:0] hcnt;

  logic [N-1:0]  pick_win;
  logic [PW-1:0] pick_idx;
  logic          pick_any;

  g_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req     (REQ),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Release and timeout share one exit test, so a coincident pair yields a single GAP.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state <= IDLE;
      GNT   <= '0;
      AN    <= G_BUF_IDLE_AN;
      ptr   <= '0;
      owner <= '0;
      hcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= OWN;
            GNT   <= pick_win;
            owner <= pick_idx;
            hcnt  <= HW'(1);
            ptr   <= (pick_idx == PLAST) ? '0 : pick_idx + PW'(1);
          end
        end
        OWN: begin
          if (!REQ[owner] || (hcnt == HMAX)) begin
            state <= GAP;
            GNT   <= '0;
            AN    <= G_BUF_IDLE_AN;
            hcnt  <= '0;
          end else begin
            AN <= ~DIN[owner];
            if (hcnt != HMAX) begin
              hcnt <= hcnt + HW'(1);
            end
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          AN    <= G_BUF_IDLE_AN;
        end
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_g_bufb_arb.sv
// Directed bench for g_bufb_arb: three instances cover N=4/MAXHOLD=16,
// N=4/MAXHOLD=4 and the non-power-of-two N=3 wrap case.
module tb_g_bufb_arb;

  logic       ck = 1'b0;
  logic       cd_a, cd_b, cd_c;
  logic [3:0] req_a, din_a, gnt_a;
  logic [3:0] req_b, din_b, gnt_b;
  logic [2:0] req_c, din_c, gnt_c;
  logic       an_a, an_b, an_c;
  logic       busy_a, busy_b, busy_c;

  int check_count = 0;
  int error_count = 0;

  always #5 ck = ~ck;

  g_bufb_arb #(.N(4), .MAXHOLD(16)) u_dut_a (
    .CK(ck), .CD(cd_a), .REQ(req_a), .DIN(din_a), .GNT(gnt_a), .AN(an_a), .BUSY(busy_a)
  );

  g_bufb_arb #(.N(4), .MAXHOLD(4)) u_dut_b (
    .CK(ck), .CD(cd_b), .REQ(req_b), .DIN(din_b), .GNT(gnt_b), .AN(an_b), .BUSY(busy_b)
  );

  g_bufb_arb #(.N(3), .MAXHOLD(16)) u_dut_c (
    .CK(ck), .CD(cd_c), .REQ(req_c), .DIN(din_c), .GNT(gnt_c), .AN(an_c), .BUSY(busy_c)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge ck);
    #1;
  endtask

  // Structural invariants on every instance, sampled mid-cycle.
  always @(negedge ck) begin
    checkOutput("inv_onehot_a", 32'($onehot0(gnt_a)), 32'd1);
    checkOutput("inv_onehot_b", 32'($onehot0(gnt_b)), 32'd1);
    checkOutput("inv_onehot_c", 32'($onehot0(gnt_c)), 32'd1);
    checkOutput("inv_an_a", 32'((gnt_a != 4'd0) || an_a), 32'd1);
    checkOutput("inv_an_b", 32'((gnt_b != 4'd0) || an_b), 32'd1);
    checkOutput("inv_an_c", 32'((gnt_c != 3'd0) || an_c), 32'd1);
  end

  initial begin
    logic [3:0] d_pat;
    logic [3:0] an_pat;
    logic [3:0] exp_gnt;
    int         o;

    cd_a = 1'b1; cd_b = 1'b1; cd_c = 1'b1;
    req_a = '0; din_a = '0;
    req_b = '0; din_b = '0;
    req_c = '0; din_c = '0;
    repeat (2) stepCycle();
    checkOutput("rst_gnt", 32'(gnt_a), 32'h0);
    checkOutput("rst_an", 32'(an_a), 32'h1);
    checkOutput("rst_busy", 32'(busy_a), 32'h0);
    cd_a = 1'b0; cd_b = 1'b0; cd_c = 1'b0;

    // Async reset pulse while owner 0 holds the line with all requests up.
    req_a = 4'b1111;
    stepCycle();
    checkOutput("first_grant", 32'(gnt_a), 32'h1);
    checkOutput("first_busy", 32'(busy_a), 32'h1);
    checkOutput("first_an_idle", 32'(an_a), 32'h1);
    stepCycle();
    #2 cd_a = 1'b1;
    #1;
    checkOutput("pulse_gnt", 32'(gnt_a), 32'h0);
    checkOutput("pulse_an", 32'(an_a), 32'h1);
    checkOutput("pulse_busy", 32'(busy_a), 32'h0);
    cd_a = 1'b0;
    stepCycle();
    checkOutput("rst_regrant", 32'(gnt_a), 32'h1);

    // Round-robin: each owner holds 3 cycles then drops and re-raises.
    for (int r = 0; r < 5; r++) begin
      o = r % 4;
      exp_gnt = 4'b0001 << o;
      checkOutput("rr_grant", 32'(gnt_a), 32'(exp_gnt));
      repeat (2) begin
        stepCycle();
        checkOutput("rr_hold", 32'(gnt_a), 32'(exp_gnt));
      end
      req_a[o] = 1'b0;
      stepCycle();
      checkOutput("rr_gap1", 32'(gnt_a), 32'h0);
      req_a[o] = 1'b1;
      stepCycle();
      checkOutput("rr_gap2", 32'(gnt_a), 32'h0);
      stepCycle();
    end
    req_a = '0;
    stepCycle();
    checkOutput("rr_release", 32'(gnt_a), 32'h0);
    stepCycle();

    // Data forwarding from owner 2; DIN[0] carries the opposite pattern as noise.
    d_pat  = 4'b1101;
    an_pat = 4'b0010;
    req_a  = 4'b0100;
    stepCycle();
    checkOutput("fwd_grant", 32'(gnt_a), 32'h4);
    for (int i = 0; i < 4; i++) begin
      din_a[2] = d_pat[i];
      din_a[0] = ~d_pat[i];
      stepCycle();
      checkOutput("fwd_an", 32'(an_a), 32'(an_pat[i]));
    end
    req_a = '0;
    stepCycle();
    checkOutput("fwd_rel_an", 32'(an_a), 32'h1);
    checkOutput("fwd_rel_gnt", 32'(gnt_a), 32'h0);
    stepCycle();

    // Timeout with MAXHOLD=4 on requester 1 alone.
    req_b = 4'b0010;
    stepCycle();
    checkOutput("to_grant", 32'(gnt_b), 32'h2);
    repeat (3) begin
      stepCycle();
      checkOutput("to_hold", 32'(gnt_b), 32'h2);
    end
    stepCycle();
    checkOutput("to_gap1", 32'(gnt_b), 32'h0);
    checkOutput("to_gap1_an", 32'(an_b), 32'h1);
    stepCycle();
    checkOutput("to_gap2", 32'(gnt_b), 32'h0);
    stepCycle();
    checkOutput("to_regrant", 32'(gnt_b), 32'h2);

    // Requester 3 joins during the hold and must win after the timeout.
    req_b = 4'b1010;
    repeat (3) begin
      stepCycle();
      checkOutput("fair_hold", 32'(gnt_b), 32'h2);
    end
    stepCycle();
    checkOutput("fair_gap1", 32'(gnt_b), 32'h0);
    stepCycle();
    checkOutput("fair_gap2", 32'(gnt_b), 32'h0);
    stepCycle();
    checkOutput("to_fair", 32'(gnt_b), 32'h8);

    // Owner 3 drops REQ on the very cycle hcnt reaches MAXHOLD.
    req_b = 4'b1000;
    repeat (3) begin
      stepCycle();
      checkOutput("sim_hold", 32'(gnt_b), 32'h8);
    end
    req_b = '0;
    stepCycle();
    checkOutput("sim_gap_gnt", 32'(gnt_b), 32'h0);
    checkOutput("sim_gap_busy", 32'(busy_b), 32'h1);
    req_b = 4'b1000;
    stepCycle();
    checkOutput("sim_idle_gnt", 32'(gnt_b), 32'h0);
    checkOutput("sim_idle_busy", 32'(busy_b), 32'h0);
    stepCycle();
    checkOutput("sim_regrant", 32'(gnt_b), 32'h8);
    req_b = '0;
    repeat (2) stepCycle();

    // N=3: grant 1 moves ptr to 2, then REQ=011 must wrap to 0 and leave ptr=1.
    req_c = 3'b010;
    stepCycle();
    checkOutput("wrap_pre", 32'(gnt_c), 32'h2);
    req_c = '0;
    repeat (2) stepCycle();
    req_c = 3'b011;
    stepCycle();
    checkOutput("wrap_win", 32'(gnt_c), 32'h1);
    req_c = '0;
    stepCycle();
    req_c = 3'b011;
    stepCycle();
    stepCycle();
    checkOutput("wrap_ptr", 32'(gnt_c), 32'h2);
    req_c = '0;
    repeat (2) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
